spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 138 +++++++++++++
 tb/tb_spi_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// Round-robin arbiter granting one of NREQ requesters access to a single SPI master.
// Tracks each transfer through START/WAIT/DONE and aborts with err when the master never answers.
module spi_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic [DW-1:0]        rsp_data,
  output logic                 busy,
  output logic                 m_start,
  output logic [DW-1:0]        m_tx_data,
  input  logic                 m_ready,
  input  logic [DW-1:0]        m_rx_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] last;
  logic [IW-1:0] winner;
  logic [IW-1:0] pick;
  logic          pick_vld;
  logic [IW:0]   idx;
  logic [CW-1:0] cnt;
  logic          err_flag;
  logic          timeout_hit;

  // The counter holds k-1 in the k-th WAIT cycle, so this fires on the cycle that
  // would bring it to TIMEOUT; DONE then lands TIMEOUT+1 cycles after m_start.
  assign timeout_hit = (cnt == CNT_LAST);

  // Scan from last+1 upward (with wrap) and take the first active request.
  always_comb begin
    pick     = last;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = {1'b0, last} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (!pick_vld && req[idx[IW-1:0]]) begin
        pick     = idx[IW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (m_ready || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last      <= IW'(NREQ - 1);
      winner    <= '0;
      cnt       <= '0;
      err_flag  <= 1'b0;
      m_tx_data <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_vld) begin
            winner    <= pick;
            m_tx_data <= req_data[pick*DW +: DW];
          end
        end
        START: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A reply arriving on the timeout cycle still counts as a completion.
          if (m_ready) begin
            rsp_data <= m_rx_data;
            err_flag <= 1'b0;
          end else if (timeout_hit) begin
            err_flag <= 1'b1;
          end
        end
        DONE:    last <= winner;
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt     = '0;
    done    = '0;
    err     = 1'b0;
    m_start = 1'b0;
    busy    = 1'b1;
    case (state)
      IDLE:  busy = 1'b0;
      START: begin
        gnt[winner] = 1'b1;
        m_start     = 1'b1;
      end
      WAIT:  gnt[winner] = 1'b1;
      DONE: begin
        gnt[winner]  = 1'b1;
        done[winner] = 1'b1;
        err          = err_flag;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      assert ($onehot0(gnt));
      assert ((done & ~gnt) == '0);
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: table of transfers with a scoreboard of expected grants and
// completions, followed by hand-written sequences for START-ready, mid-transfer and reset cases.
module tb_spi_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 255;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [DW-1:0]     rsp_data;
  logic              busy;
  logic              m_start;
  logic [DW-1:0]     m_tx_data;
  logic              m_ready = 1'b0;
  logic [DW-1:0]     m_rx_data = '0;

  logic [7:0] txw [4] = '{8'hA5, 8'hB2, 8'hC3, 8'hD4};
  assign req_data = {txw[3], txw[2], txw[1], txw[0]};

  spi_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .rsp_data(rsp_data), .busy(busy),
    .m_start(m_start), .m_tx_data(m_tx_data), .m_ready(m_ready), .m_rx_data(m_rx_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] tx;
    logic       err;
    logic [7:0] rsp;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    int         dly;      // cycles from m_start to m_ready; -1 = never answer
    logic [7:0] rx;
    logic [3:0] exp_gnt;
    logic       exp_err;
    logic [7:0] exp_rsp;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t vecs[13];
  int   total = 0;
  int   bad = 0;
  bit   mon_on = 1'b0;
  int   done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic logic [7:0] tx_of(input logic [3:0] g);
    tx_of = 8'h00;
    for (int i = 0; i < 4; i++) if (g[i]) tx_of = txw[i];
  endfunction

  // Scoreboard side: compare every start strobe and completion with the queue head.
  always @(negedge clock) begin
    if (mon_on) begin
      if (m_start) begin
        if (sbq.size() == 0) check("start_unexpected", 32'(gnt), 32'(0));
        else begin
          check("start_gnt", 32'(gnt), 32'(sbq[0].gnt));
          check("start_tx", 32'(m_tx_data), 32'(sbq[0].tx));
        end
      end
      if (done != '0) begin
        done_seen++;
        if (sbq.size() == 0) check("done_unexpected", 32'(done), 32'(0));
        else begin
          mon_e = sbq.pop_front();
          check("done_bit", 32'(done), 32'(mon_e.gnt));
          check("done_gnt", 32'(gnt), 32'(mon_e.gnt));
          check("done_err", 32'(err), 32'(mon_e.err));
          check("done_rsp", 32'(rsp_data), 32'(mon_e.rsp));
        end
      end
    end
  end

  task automatic wait_start(output int n);
    n = 0;
    while (!m_start && n < 20) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int start_wait);
    int   n;
    exp_t e;
    e.gnt = v.exp_gnt;
    e.tx  = tx_of(v.exp_gnt);
    e.err = v.exp_err;
    e.rsp = v.exp_rsp;
    sbq.push_back(e);
    req = v.req;
    wait_start(n);
    check("start_latency", 32'(n), 32'(start_wait));
    if (!m_start) return;
    n = 0;
    if (v.dly >= 0) begin
      repeat (v.dly) @(negedge clock);
      m_ready   = 1'b1;
      m_rx_data = v.rx;
      @(negedge clock);
      m_ready   = 1'b0;
      m_rx_data = 8'h00;
      n = v.dly + 1;
    end
    while (done == '0 && n < TIMEOUT + 20) begin
      @(negedge clock);
      n++;
    end
    check("done_latency", 32'(n), 32'((v.dly >= 0) ? v.dly + 1 : TIMEOUT + 1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  32'(gnt), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_err"},  32'(err), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_mstart"}, 32'(m_start), 32'(0));
    check({tag, "_mtx"},  32'(m_tx_data), 32'(0));
    check({tag, "_rsp"},  32'(rsp_data), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    int   ds;
    exp_t e;

    vecs[0]  = '{4'b0001,  16, 8'h3C, 4'b0001, 1'b0, 8'h3C};
    vecs[1]  = '{4'b1000,   3, 8'h5A, 4'b1000, 1'b0, 8'h5A};
    vecs[2]  = '{4'b1111,   1, 8'h11, 4'b0001, 1'b0, 8'h11};
    vecs[3]  = '{4'b1111,   2, 8'h22, 4'b0010, 1'b0, 8'h22};
    vecs[4]  = '{4'b1111,   4, 8'h33, 4'b0100, 1'b0, 8'h33};
    vecs[5]  = '{4'b1111,   7, 8'h44, 4'b1000, 1'b0, 8'h44};
    vecs[6]  = '{4'b1111,   1, 8'h55, 4'b0001, 1'b0, 8'h55};
    vecs[7]  = '{4'b0100,  -1, 8'h00, 4'b0100, 1'b1, 8'h55};
    vecs[8]  = '{4'b0100, 255, 8'h66, 4'b0100, 1'b0, 8'h66};
    vecs[9]  = '{4'b0011,   5, 8'h77, 4'b0001, 1'b0, 8'h77};
    vecs[10] = '{4'b0011,   5, 8'h88, 4'b0010, 1'b0, 8'h88};
    vecs[11] = '{4'b1000,   6, 8'h99, 4'b1000, 1'b0, 8'h99};
    vecs[12] = '{4'b1000,   9, 8'hAA, 4'b1000, 1'b0, 8'hAA};

    repeat (3) @(negedge clock);
    reset = 1'b1;
    check_all_zero("reset");
    mon_on = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], (i == 0) ? 1 : 2);

    // m_ready during START must be ignored.
    e = '{4'b0001, 8'hA5, 1'b0, 8'hBB};
    sbq.push_back(e);
    req = 4'b0001;
    wait_start(n);
    check("ign_start_latency", 32'(n), 32'(2));
    m_ready = 1'b1; m_rx_data = 8'hEE;
    @(negedge clock);
    m_ready = 1'b0; m_rx_data = 8'h00;
    check("ign_done", 32'(done), 32'(0));
    check("ign_busy", 32'(busy), 32'(1));
    check("mstart_one_cycle", 32'(m_start), 32'(0));
    repeat (3) @(negedge clock);
    m_ready = 1'b1; m_rx_data = 8'hBB;
    @(negedge clock);
    m_ready = 1'b0; m_rx_data = 8'h00;
    check("ign_late_done", 32'(done), 32'(4'b0001));

    // Request changes while requester 0 is in WAIT.
    e = '{4'b0001, 8'hA5, 1'b0, 8'hCC};
    sbq.push_back(e);
    e = '{4'b1000, 8'hD4, 1'b0, 8'hDD};
    sbq.push_back(e);
    wait_start(n);
    check("mid_start_latency", 32'(n), 32'(2));
    repeat (2) @(negedge clock);
    req = 4'b1000;
    repeat (4) @(negedge clock);
    m_ready = 1'b1; m_rx_data = 8'hCC;
    @(negedge clock);
    m_ready = 1'b0; m_rx_data = 8'h00;
    check("mid_done0", 32'(done), 32'(4'b0001));
    @(negedge clock);
    check("mid_gap_mstart", 32'(m_start), 32'(0));
    check("mid_gap_gnt", 32'(gnt), 32'(0));
    @(negedge clock);
    check("mid_grant3_mstart", 32'(m_start), 32'(1));
    check("mid_grant3_gnt", 32'(gnt), 32'(4'b1000));
    repeat (2) @(negedge clock);
    m_ready = 1'b1; m_rx_data = 8'hDD;
    @(negedge clock);
    m_ready = 1'b0; m_rx_data = 8'h00;
    check("mid_done3", 32'(done), 32'(4'b1000));

    // Move the pointer to requester 1, then reset in the middle of a WAIT.
    run_vec('{4'b0010, 2, 8'hEE, 4'b0010, 1'b0, 8'hEE}, 2);
    e = '{4'b0010, 8'hB2, 1'b0, 8'h00};
    sbq.push_back(e);
    wait_start(n);
    check("rst_start_latency", 32'(n), 32'(2));
    repeat (3) @(negedge clock);
    reset = 1'b0;
    req   = 4'b0000;
    @(negedge clock);
    reset = 1'b1;
    check_all_zero("midrst");
    sbq.delete();
    ds = done_seen;
    repeat (10) @(negedge clock);
    check("no_done_after_abort", 32'(done_seen - ds), 32'(0));
    run_vec('{4'b0110, 3, 8'h5F, 4'b0010, 1'b0, 8'h5F}, 1);
    req = 4'b0000;
    repeat (3) @(negedge clock);

    check("queue_empty", 32'(sbq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
